// File: rtl/axi_mem_responder_pkg.sv
// Shared types for the AXI4 memory responder: write/read FSM states and burst-length width.
package axi_mem_responder_pkg;

  localparam int LEN_W = 8;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi_mem_responder_ram.sv
// Word-wide memory: byte-enable write port plus registered read-first read port.
// Array contents are deliberately not reset; only the read output register is.
module axi_mem_responder_ram #(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [DATA_W/8-1:0]      wstrb_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Reads sample the array before this edge's write lands, giving old data on collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 INCR-burst slave backed by internal memory; independent read and write FSMs.
// Reads: first beat one cycle after AR, then one beat per cycle while rready is held.
module axi_mem_responder
  import axi_mem_responder_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_MEM_DEPTH        = 1024
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [LEN_W-1:0]                s_axi_awlen,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [LEN_W-1:0]                s_axi_arlen,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast,
  output logic                            err_wlast
);

  localparam int OFF_W = $clog2(C_M_AXI_DATA_WIDTH / 8);
  localparam int IDX_W = $clog2(C_MEM_DEPTH);

  logic [IDX_W-1:0] aw_idx, ar_idx;
  logic             unused_addr;

  assign aw_idx      = s_axi_awaddr[OFF_W +: IDX_W];
  assign ar_idx      = s_axi_araddr[OFF_W +: IDX_W];
  assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};

  wr_state_t        wr_state_q, wr_state_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [LEN_W-1:0] wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic             err_q, err_d;
  logic             ram_we;

  rd_state_t        rd_state_q, rd_state_d;
  logic [IDX_W-1:0] ridx_q, ridx_d, ram_raddr;
  logic [LEN_W-1:0] rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic             ram_re;

  always_comb begin
    wr_state_d    = wr_state_q;
    widx_d        = widx_q;
    wlen_d        = wlen_q;
    wcnt_d        = wcnt_q;
    err_d         = err_q;
    ram_we        = 1'b0;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) begin
          widx_d     = aw_idx;
          wlen_d     = s_axi_awlen;
          wcnt_d     = '0;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          ram_we = 1'b1;
          widx_d = widx_q + 1'b1;
          // Burst length follows awlen; a misplaced wlast is only flagged.
          if (s_axi_wlast != (wcnt_q == wlen_q)) err_d = 1'b1;
          if (wcnt_q == wlen_q) wr_state_d = W_RESP;
          else                  wcnt_d     = wcnt_q + 1'b1;
        end
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d    = rd_state_q;
    ridx_d        = ridx_q;
    rlen_d        = rlen_q;
    rcnt_d        = rcnt_q;
    ram_re        = 1'b0;
    ram_raddr     = ridx_q;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) begin
          ram_re     = 1'b1;
          ram_raddr  = ar_idx;
          ridx_d     = ar_idx + 1'b1;
          rlen_d     = s_axi_arlen;
          rcnt_d     = '0;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        s_axi_rlast  = (rcnt_q == rlen_q);
        // Prefetch the next word on each accepted beat; a stall leaves the RAM output untouched.
        if (s_axi_rready) begin
          if (rcnt_q == rlen_q) begin
            rd_state_d = R_IDLE;
          end else begin
            ram_re = 1'b1;
            ridx_d = ridx_q + 1'b1;
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_state_q <= W_IDLE;
      widx_q     <= '0;
      wlen_q     <= '0;
      wcnt_q     <= '0;
      err_q      <= 1'b0;
      rd_state_q <= R_IDLE;
      ridx_q     <= '0;
      rlen_q     <= '0;
      rcnt_q     <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      widx_q     <= widx_d;
      wlen_q     <= wlen_d;
      wcnt_q     <= wcnt_d;
      err_q      <= err_d;
      rd_state_q <= rd_state_d;
      ridx_q     <= ridx_d;
      rlen_q     <= rlen_d;
      rcnt_q     <= rcnt_d;
    end
  end

  assign err_wlast = err_q;

  axi_mem_responder_ram #(
    .DATA_W (C_M_AXI_DATA_WIDTH),
    .DEPTH  (C_MEM_DEPTH)
  ) u_ram (
    .clk_i   (ap_clk),
    .rst_ni  (ap_rst_n),
    .we_i    (ram_we),
    .waddr_i (widx_q),
    .wdata_i (s_axi_wdata),
    .wstrb_i (s_axi_wstrb),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (s_axi_rdata)
  );

endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 The block SHALL have parameter C_M_AXI_ADDR_WIDTH, default 64, AXI address width.
REQ-002 The block SHALL have parameter C_M_AXI_DATA_WIDTH, default 512, AXI data width; power of two, at least 32.
REQ-003 The block SHALL have parameter C_MEM_DEPTH, default 1024, memory depth in data-width words; power of two.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low (ap_clk, ap_rst_n).
REQ-005 The block SHALL have port ap_clk, input, width 1: the single clock.
REQ-006 The block SHALL have port ap_rst_n, input, width 1: asynchronous active-low reset.
REQ-007 The block SHALL have port group s_axi_awvalid/awready/awaddr/awlen: input/output/input/input, widths 1/1/ADDR/8, write address channel.
REQ-008 The block SHALL have port group s_axi_wvalid/wready/wdata/wstrb/wlast: in/out/in/in/in, widths 1/1/DATA/DATA/8/1, write data channel.
REQ-009 The block SHALL have port group s_axi_bvalid/bready: out/in, widths 1/1, write response channel (no BRESP; always OKAY).
REQ-010 The block SHALL have port group s_axi_arvalid/arready/araddr/arlen: out-direction arready, others input, widths 1/1/ADDR/8, read address channel.
REQ-011 The block SHALL have port group s_axi_rvalid/rready/rdata/rlast: out/in/out/out, widths 1/1/DATA/1, read data channel.
REQ-012 The block SHALL have port err_wlast, output, width 1: sticky WLAST-protocol error flag.

Function
REQ-013 The block SHALL be the AXI4 INCR-burst slave counterpart to the team's read/write masters, backed by internal memory of C_MEM_DEPTH words.
REQ-014 Word index SHALL be addr[$clog2(DATA/8) +: $clog2(C_MEM_DEPTH)]; low byte-offset bits are ignored and upper bits are discarded (modulo wrap).
REQ-015 Within a burst the word index SHALL increment by 1 per beat and wrap from C_MEM_DEPTH-1 to 0.
REQ-016 The write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE; wready=1 only in W_DATA; bvalid=1 only in W_RESP.
REQ-017 W_IDLE->W_DATA on awvalid&awready, latching index and awlen; beat counter cleared.
REQ-018 In W_DATA, on each wvalid&wready, bytes with wstrb=1 SHALL be written and all others kept; the FSM SHALL exit to W_RESP after exactly awlen+1 beats.
REQ-019 err_wlast SHALL set if wlast differs from (beat==awlen) on any accepted beat; the burst length is still governed by awlen.
REQ-020 W_RESP->W_IDLE on bvalid&bready; bvalid SHALL hold until accepted.
REQ-021 The read FSM SHALL have states R_IDLE, R_DATA; arready=1 only in R_IDLE.
REQ-022 On ar handshake in cycle N, the first rvalid SHALL appear in cycle N+1; subsequent beats SHALL follow in consecutive cycles while rready=1 (full throughput).
REQ-023 rdata/rvalid/rlast SHALL hold stable while rvalid&!rready; rlast=1 exactly on beat arlen.
REQ-024 On the final r handshake the FSM SHALL return to R_IDLE; the next arready is asserted in the following cycle.
REQ-025 The read and write channels SHALL operate concurrently and independently.
REQ-026 For a same-cycle write and read-fetch to the same word, the read SHALL return the old data (read-first).
REQ-027 awlen=0 / arlen=0 SHALL produce single-beat bursts with wlast/rlast on beat 0.

Reset
REQ-028 Reset SHALL force W_IDLE and R_IDLE; awready=1 and arready=1 on the first cycle after deassertion; wready, bvalid, rvalid, rlast, err_wlast=0; rdata=0.
REQ-029 Reset mid-burst SHALL abandon the burst without a B or R response; memory contents SHALL be preserved (not initialised).
REQ-030 err_wlast SHALL clear only on reset.

Structure
REQ-031 Package axi_mem_responder_pkg SHALL hold the wr_state_t and rd_state_t enums and the burst-length width constant (8).
REQ-032 The memory SHALL be sub-module axi_mem_responder_ram: one byte-enable write port plus one registered read-first read port.

Verification
REQ-033 Scenario: write to awaddr 0x0, awlen=3, data words 0xA0..0xA3 with all strobes set, then read araddr 0x0, arlen=3 -> rdata 0xA0..0xA3 returned, rlast on beat 3, a single bvalid, err_wlast=0.
REQ-034 Scenario: write word 1 with wstrb=0x1 and wdata byte 0x5A over a prior value of all ones, then read it back -> byte0=0x5A, all other bytes 0xFF.
REQ-035 Scenario: write at index C_MEM_DEPTH-2, awlen=3 -> indices 1022, 1023, 0, 1 are written; readback at index 0 returns beat 2.
REQ-036 Scenario: read arlen=7 with rready toggling at 50% -> 8 beats delivered in order, with data stable during stalls.
REQ-037 Scenario: write with wlast asserted on beat 1 of awlen=3 -> err_wlast=1, and bvalid appears after 4 beats.
REQ-038 Scenario: assert ap_rst_n low during a read burst, then re-issue the read -> correct data, with no stale rvalid after reset.
